custom_ip_reg_arbiter: RTL and testbench

CUSTOM_IP_REG_ARBITER -- requirements
Module: custom_ip_reg_arbiter

---
 rtl/custom_ip_reg_arbiter.sv | 142 ++++++++++++++
 tb/tb_custom_ip_reg_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/custom_ip_reg_arbiter.sv
// Round-robin arbiter that shares one three-word custom IP register port among NUM_REQ requesters.
// A shadow copy of the IP words keeps unaddressed words intact when the IP reloads all words together.
module custom_ip_reg_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 96
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ-1:0]      req_we_i,
  input  logic [2*NUM_REQ-1:0]    req_addr_i,
  input  logic [32*NUM_REQ-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  output logic                    rsp_err_o,
  output logic [31:0]             rsp_rdata_o,
  output logic [DATA_WIDTH-1:0]   reg2ip_data_o,
  output logic [2:0]              reg2ip_en_o,
  input  logic [DATA_WIDTH+2:0]   ip2reg_data_i
);

  localparam int IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_WORDS = DATA_WIDTH / 32;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_RDWAIT = 3'd2;
  localparam logic [2:0] S_RDCAP  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]            state_q;
  logic [IW-1:0]         last_q;
  logic [IW-1:0]         idx_q;
  logic                  we_q;
  logic [1:0]            addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic [DATA_WIDTH-1:0] shadow_q;

  logic [NUM_REQ-1:0]    rot;
  logic                  win_valid;
  int                    sel;
  logic [IW-1:0]         win_idx;
  logic                  win_we;
  logic [1:0]            win_addr;
  logic [31:0]           win_wdata;
  logic [DATA_WIDTH-1:0] write_data;
  logic [31:0]           ip_field;
  logic [NUM_WORDS-1:0]  unused_ip_bits;
  logic                  addr_err;

  // Rotate requests so bit 0 is the requester just after the last winner.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    rot       = NUM_REQ'({req_i, req_i} >> (int'(last_q) + 1));
    win_valid = 1'b0;
    sel       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_valid && rot[i]) begin
        win_valid = 1'b1;
        sel       = int'(last_q) + 1 + i;
      end
    end
    if (sel >= NUM_REQ) sel = sel - NUM_REQ;
    win_idx   = IW'(sel);
    win_we    = 1'b0;
    win_addr  = 2'd0;
    win_wdata = 32'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IW'(k)) begin
        win_we    = req_we_i[k];
        win_addr  = req_addr_i[2*k +: 2];
        win_wdata = req_wdata_i[32*k +: 32];
      end
    end
  end

  // Word 0 sits in the most significant slot; readback fields are 33 bits apart.
  always_comb begin
    write_data = shadow_q;
    ip_field   = 32'd0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (addr_q == 2'(k)) begin
        write_data[DATA_WIDTH-1-32*k -: 32] = wdata_q;
        ip_field = ip2reg_data_i[DATA_WIDTH+2-33*k -: 32];
      end
      unused_ip_bits[k] = ip2reg_data_i[DATA_WIDTH+2-33*k-32];
    end
  end

  assign addr_err = (addr_q == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the shadow is a plain register (not a RAM), so it is safe and required to reset it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      last_q   <= IW'(NUM_REQ - 1);
      idx_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= 2'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      shadow_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            last_q  <= win_idx;
            idx_q   <= win_idx;
            we_q    <= win_we;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            if (win_addr == 2'd3) state_q <= S_RESP;
            else if (win_we)      state_q <= S_WRITE;
            else                  state_q <= S_RDWAIT;
          end
        end
        S_WRITE: begin
          shadow_q <= write_data;
          state_q  <= S_RESP;
        end
        S_RDWAIT: state_q <= S_RDCAP;
        S_RDCAP: begin
          rdata_q <= ip_field;
          state_q <= S_RESP;
        end
        S_RESP:   state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // The grant is combinational on req_i in IDLE, so it is masked while reset is held.
  assign gnt_o         = (state_q == S_IDLE && win_valid && !rst_i) ? (NUM_REQ'(1) << win_idx) : '0;
  assign rsp_valid_o   = (state_q == S_RESP) ? (NUM_REQ'(1) << idx_q) : '0;
  assign rsp_err_o     = (state_q == S_RESP) && addr_err;
  assign rsp_rdata_o   = (state_q == S_RESP && !we_q && !addr_err) ? rdata_q : 32'd0;
  assign reg2ip_en_o   = (state_q == S_WRITE) ? (3'b001 << addr_q) : 3'b000;
  assign reg2ip_data_o = (state_q == S_WRITE) ? write_data : shadow_q;

endmodule

// File: tb/tb_custom_ip_reg_arbiter.sv
// Directed testbench for custom_ip_reg_arbiter: reset, arbitration order, writes, reads, errors
// and reset in the middle of a write; inputs change on the falling edge, outputs checked 1 ns later.
module tb_custom_ip_reg_arbiter;

  localparam int NUM_REQ    = 3;
  localparam int DATA_WIDTH = 96;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [NUM_REQ-1:0]    req_i;
  logic [NUM_REQ-1:0]    req_we_i;
  logic [2*NUM_REQ-1:0]  req_addr_i;
  logic [32*NUM_REQ-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]    gnt_o;
  logic [NUM_REQ-1:0]    rsp_valid_o;
  logic                  rsp_err_o;
  logic [31:0]           rsp_rdata_o;
  logic [DATA_WIDTH-1:0] reg2ip_data_o;
  logic [2:0]            reg2ip_en_o;
  logic [DATA_WIDTH+2:0] ip2reg_data_i;

  int total = 0;
  int bad   = 0;

  custom_ip_reg_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .req_we_i      (req_we_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .gnt_o         (gnt_o),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .reg2ip_data_o (reg2ip_data_o),
    .reg2ip_en_o   (reg2ip_en_o),
    .ip2reg_data_i (ip2reg_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    req_i = '0;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  // Grant cycle: drive requester k alone, check its grant, then drop the request.
  task automatic issue(input int k, input logic we, input logic [1:0] addr, input logic [31:0] wdata);
    tick();
    req_i                     = '0;
    req_i[k]                  = 1'b1;
    req_we_i[k]               = we;
    req_addr_i[2*k +: 2]      = addr;
    req_wdata_i[32*k +: 32]   = wdata;
    #1 check("gnt", gnt_o, 128'(NUM_REQ'(1) << k));
    tick();
    req_i = '0;
    #1;
  endtask

  logic [NUM_REQ-1:0] exp_gnt [12];
  logic [NUM_REQ-1:0] exp_rsp [12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i         = 1'b1;
    req_i         = 3'b111;
    req_we_i      = 3'b111;
    req_addr_i    = {2'd2, 2'd1, 2'd0};
    req_wdata_i   = {32'hCCCC2222, 32'hBBBB1111, 32'hAAAA0000};
    ip2reg_data_i = {32'h00002468, 1'b1, 32'h0000369C, 1'b1, 32'h000048D0, 1'b1};

    // Reset held with all requesters active: every output stays quiet.
    tick(); tick();
    #1;
    check("rst_gnt",   gnt_o,         '0);
    check("rst_rsp",   rsp_valid_o,   '0);
    check("rst_err",   rsp_err_o,     '0);
    check("rst_rdata", rsp_rdata_o,   '0);
    check("rst_en",    reg2ip_en_o,   '0);
    check("rst_data",  reg2ip_data_o, '0);

    // Round-robin among three held writers, starting at requester 0 after reset.
    foreach (exp_gnt[c]) begin
      exp_gnt[c] = '0;
      exp_rsp[c] = '0;
    end
    exp_gnt[0] = 3'b001; exp_gnt[3] = 3'b010; exp_gnt[6] = 3'b100; exp_gnt[9]  = 3'b001;
    exp_rsp[2] = 3'b001; exp_rsp[5] = 3'b010; exp_rsp[8] = 3'b100; exp_rsp[11] = 3'b001;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 0) rst_i = 1'b0;
      if (c == 10) req_i = '0;
      #1;
      check($sformatf("rr_gnt_c%0d", c), gnt_o, exp_gnt[c]);
      check($sformatf("rr_rsp_c%0d", c), rsp_valid_o, exp_rsp[c]);
      if (c == 7) begin
        check("rr_en_c7",   reg2ip_en_o,   3'b100);
        check("rr_data_c7", reg2ip_data_o, {32'hAAAA0000, 32'hBBBB1111, 32'hCCCC2222});
      end
    end

    // Shadow merge: second write must keep the first word.
    do_reset();
    issue(1, 1'b1, 2'd2, 32'h22222222);
    check("m1_en",   reg2ip_en_o,   3'b100);
    check("m1_data", reg2ip_data_o, {32'h0, 32'h0, 32'h22222222});
    tick();
    issue(2, 1'b1, 2'd0, 32'h11111111);
    check("m2_en",   reg2ip_en_o,   3'b001);
    check("m2_data", reg2ip_data_o, {32'h11111111, 32'h0, 32'h22222222});
    tick(); #1;
    check("m2_rsp",   rsp_valid_o, 3'b100);
    check("m2_err",   rsp_err_o,   1'b0);
    check("m2_rdata", rsp_rdata_o, 32'h0);

    // Single write from a clean shadow.
    do_reset();
    issue(0, 1'b1, 2'd1, 32'hDEADBEEF);
    check("w_en",   reg2ip_en_o,   3'b010);
    check("w_data", reg2ip_data_o, {32'h0, 32'hDEADBEEF, 32'h0});
    check("w_rsp1", rsp_valid_o,   3'b000);
    tick(); #1;
    check("w_rsp2",   rsp_valid_o, 3'b001);
    check("w_err",    rsp_err_o,   1'b0);
    check("w_rdata",  rsp_rdata_o, 32'h0);
    check("w_en_off", reg2ip_en_o, 3'b000);
    tick(); #1;
    check("w_shadow", reg2ip_data_o, {32'h0, 32'hDEADBEEF, 32'h0});

    // Reads of each field; ignored separator bits are driven high.
    issue(1, 1'b0, 2'd1, 32'h0);
    check("r1_en_c1", reg2ip_en_o, 3'b000);
    check("r1_rsp_c1", rsp_valid_o, 3'b000);
    tick(); #1;
    check("r1_en_c2", reg2ip_en_o, 3'b000);
    check("r1_rsp_c2", rsp_valid_o, 3'b000);
    tick(); #1;
    check("r1_rsp",   rsp_valid_o, 3'b010);
    check("r1_rdata", rsp_rdata_o, 32'h0000369C);
    check("r1_err",   rsp_err_o,   1'b0);
    check("r1_en_c3", reg2ip_en_o, 3'b000);
    tick(); #1;
    check("r1_rdata_idle", rsp_rdata_o, 32'h0);
    check("r1_rsp_idle",   rsp_valid_o, 3'b000);

    issue(2, 1'b0, 2'd2, 32'h0);
    tick(); tick(); #1;
    check("r2_rsp",   rsp_valid_o, 3'b100);
    check("r2_rdata", rsp_rdata_o, 32'h000048D0);
    tick();
    issue(0, 1'b0, 2'd0, 32'h0);
    tick(); tick(); #1;
    check("r0_rsp",   rsp_valid_o, 3'b001);
    check("r0_rdata", rsp_rdata_o, 32'h00002468);
    tick();

    // Address 3 write: error response next cycle, no enable, shadow untouched.
    issue(2, 1'b1, 2'd3, 32'hFFFFFFFF);
    check("e_rsp",   rsp_valid_o,   3'b100);
    check("e_err",   rsp_err_o,     1'b1);
    check("e_rdata", rsp_rdata_o,   32'h0);
    check("e_en",    reg2ip_en_o,   3'b000);
    check("e_data",  reg2ip_data_o, {32'h0, 32'hDEADBEEF, 32'h0});
    tick(); #1;
    check("e_err_idle", rsp_err_o, 1'b0);

    // Reset during a WRITE cycle: no response and the partial write is lost.
    issue(0, 1'b1, 2'd0, 32'hCAFEF00D);
    check("x_en", reg2ip_en_o, 3'b001);
    #1 rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check("x_en_off", reg2ip_en_o, 3'b000);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("x_rsp_c%0d", c), rsp_valid_o, 3'b000);
      check($sformatf("x_data_c%0d", c), reg2ip_data_o, '0);
      tick(); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
